// File: rtl/custom_timings_pkg.sv
// Shared timing definitions for the super-res VRAM fetch path.
// Slot phases, fetch FSM states and line column limits.
package custom_timings;

  typedef enum logic [1:0] {
    PH_DL = 2'd0,
    PH_DR = 2'd1,
    PH_AP = 2'd2,
    PH_FS = 2'd3
  } phase_t;

  typedef enum logic [1:0] {
    IDLE,
    VID_WAIT,
    CPU_WAIT
  } state_t;

  localparam logic [10:0] FETCH_END = 11'd720;
  localparam logic [10:0] LAST_COL  = 11'd723;

  function automatic logic [3:0] lane_mask(
    input logic [1:0] lane
  );
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/vdp_super_vram_fetch.sv
// Super-res VRAM slot arbiter: video reads win each FS slot,
// a single buffered CPU byte write fills the idle slots.
module vdp_super_vram_fetch
  import custom_timings::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        super_high_res,
  input  logic [10:0] cx,
  input  logic        last_line,
  input  logic        fetch_line,
  input  logic [16:0] high_res_vram_addr,
  output logic [31:0] vrm_32,
  input  logic        cpu_wr_req,
  input  logic [16:0] cpu_addr,
  input  logic [1:0]  cpu_lane,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_busy,
  output logic        cpu_wr_ack,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [16:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rdata_valid,
  output logic        underrun
);

  state_t      state;
  state_t      state_nx;
  phase_t      phase;
  logic        is_fs;
  logic        is_dl;
  logic        is_dr;
  logic        vid_slot;
  logic        vrm_load;
  logic        set_underrun;
  logic        shr_q;
  logic        buf_full;
  logic [16:0] buf_addr;
  logic [1:0]  buf_lane;
  logic [7:0]  buf_data;

  assign phase = phase_t'(cx[1:0]);
  assign is_fs = (phase == PH_FS);
  assign is_dl = (phase == PH_DL);
  assign is_dr = (phase == PH_DR);

  assign vid_slot = super_high_res &&
    ((fetch_line && (cx < FETCH_END)) ||
     ((cx == LAST_COL) && last_line));

  assign cpu_busy = buf_full;

  // Slot decode: issue the FS request and steer the wait states.
  // Requests are gated by reset_n so outputs stay low in reset.
  always_comb begin
    state_nx     = state;
    mem_req      = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_wmask    = '0;
    vrm_load     = 1'b0;
    set_underrun = 1'b0;
    cpu_wr_ack   = 1'b0;
    unique case (state)
      IDLE: begin
        if (reset_n && is_fs) begin
          if (vid_slot) begin
            mem_req  = 1'b1;
            mem_addr = high_res_vram_addr;
            state_nx = VID_WAIT;
          end else if (buf_full) begin
            mem_req   = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = buf_addr;
            mem_wdata = {4{buf_data}};
            mem_wmask = lane_mask(buf_lane);
            state_nx  = CPU_WAIT;
          end
        end
      end
      VID_WAIT: begin
        if (!super_high_res) begin
          state_nx = IDLE;
        end else if (is_dr) begin
          state_nx = IDLE;
        end else if (is_dl) begin
          if (mem_rdata_valid) begin
            vrm_load = 1'b1;
            state_nx = IDLE;
          end else begin
            set_underrun = 1'b1;
          end
        end
      end
      CPU_WAIT: begin
        if (is_dr) begin
          cpu_wr_ack = 1'b1;
          state_nx   = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Single-entry CPU write buffer; freed by the ack at DR.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_full <= 1'b0;
      buf_addr <= '0;
      buf_lane <= '0;
      buf_data <= '0;
    end else if (cpu_wr_req && !buf_full && !cpu_wr_ack) begin
      buf_full <= 1'b1;
      buf_addr <= cpu_addr;
      buf_lane <= cpu_lane;
      buf_data <= cpu_wdata;
    end else if (cpu_wr_ack) begin
      buf_full <= 1'b0;
    end
  end

  // Video data latch and sticky underrun, cleared on mode entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vrm_32   <= '0;
      underrun <= 1'b0;
      shr_q    <= 1'b0;
    end else begin
      shr_q <= super_high_res;
      if (vrm_load) vrm_32 <= mem_rdata;
      if (super_high_res && !shr_q) underrun <= 1'b0;
      else if (set_underrun)        underrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vdp_super_vram_fetch.sv
// Bench for vdp_super_vram_fetch: vector table, directed
// slot sequences and a randomized slot-level reference model.
module tb_vdp_super_vram_fetch;

  logic        clk;
  logic        reset_n;
  logic        shr;
  logic [10:0] cx;
  logic        ll;
  logic        fl;
  logic [16:0] hraddr;
  logic [31:0] vrm_32;
  logic        wr_req;
  logic [16:0] c_addr;
  logic [1:0]  c_lane;
  logic [7:0]  c_data;
  logic        cpu_busy;
  logic        cpu_wr_ack;
  logic        mem_req;
  logic        mem_wr;
  logic [16:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] rdata;
  logic        rvalid;
  logic        underrun;

  int n_chk;
  int n_fail;

  vdp_super_vram_fetch dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .super_high_res     (shr),
    .cx                 (cx),
    .last_line          (ll),
    .fetch_line         (fl),
    .high_res_vram_addr (hraddr),
    .vrm_32             (vrm_32),
    .cpu_wr_req         (wr_req),
    .cpu_addr           (c_addr),
    .cpu_lane           (c_lane),
    .cpu_wdata          (c_data),
    .cpu_busy           (cpu_busy),
    .cpu_wr_ack         (cpu_wr_ack),
    .mem_req            (mem_req),
    .mem_wr             (mem_wr),
    .mem_addr           (mem_addr),
    .mem_wdata          (mem_wdata),
    .mem_wmask          (mem_wmask),
    .mem_rdata          (rdata),
    .mem_rdata_valid    (rvalid),
    .underrun           (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: sim time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        shr;
    logic        fl;
    logic        ll;
    logic [10:0] c;
    logic [16:0] a;
    logic        req;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {6'd0, mem_req, mem_wr, mem_addr, mem_wdata,
            mem_wmask, cpu_wr_ack, cpu_busy, underrun};
  endfunction

  function automatic logic [63:0] wr_pack();
    return {7'd0, mem_req, mem_wr, mem_addr, mem_wdata,
            mem_wmask};
  endfunction

  task automatic go(input logic [10:0] c);
    @(posedge clk);
    #1;
    cx     = c;
    rvalid = 1'b0;
    wr_req = 1'b0;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    shr     = 1'b0;
    fl      = 1'b0;
    ll      = 1'b0;
    cx      = 11'd0;
    rvalid  = 1'b0;
    wr_req  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic cpu_wr(input logic [16:0] a,
                        input logic [1:0] l,
                        input logic [7:0] d);
    wr_req = 1'b1;
    c_addr = a;
    c_lane = l;
    c_data = d;
  endtask

  // reference model state
  logic        m_busy;
  logic [16:0] m_addr;
  logic [1:0]  m_lane;
  logic [7:0]  m_data;
  logic [31:0] m_vrm;
  logic        m_under;
  logic        m_shr_prev;
  int          slot;
  int          vid_lat;
  logic [31:0] vid_data;

  initial begin
    int bad;
    logic [31:0] held;
    n_chk   = 0;
    n_fail  = 0;
    rdata   = '0;
    c_addr  = '0;
    c_lane  = '0;
    c_data  = '0;

    vt[0] = '{1'b1, 1'b1, 1'b0, 11'd3,   17'h00010, 1'b1};
    vt[1] = '{1'b1, 1'b1, 1'b0, 11'd719, 17'h1F00F, 1'b1};
    vt[2] = '{1'b1, 1'b1, 1'b0, 11'd723, 17'h00123, 1'b0};
    vt[3] = '{1'b1, 1'b0, 1'b1, 11'd723, 17'h0ABCD, 1'b1};
    vt[4] = '{1'b0, 1'b1, 1'b0, 11'd3,   17'h00044, 1'b0};
    vt[5] = '{1'b1, 1'b0, 1'b0, 11'd3,   17'h00055, 1'b0};
    vt[6] = '{1'b1, 1'b1, 1'b0, 11'd4,   17'h00066, 1'b0};
    vt[7] = '{1'b1, 1'b1, 1'b0, 11'd2,   17'h00077, 1'b0};
    vt[8] = '{1'b1, 1'b0, 1'b1, 11'd719, 17'h00088, 1'b0};
    vt[9] = '{1'b1, 1'b1, 1'b1, 11'd727, 17'h00099, 1'b0};

    // reset holds all outputs low despite active inputs
    reset_n = 1'b0;
    shr     = 1'b1;
    fl      = 1'b1;
    ll      = 1'b1;
    cx      = 11'd3;
    hraddr  = 17'h1FFFF;
    rvalid  = 1'b1;
    rdata   = 32'hFFFF_FFFF;
    wr_req  = 1'b1;
    #22;
    chk("reset_outs", outs(), 64'd0);
    chk("reset_vrm", {32'd0, vrm_32}, 64'd0);

    // FS classification table
    for (int i = 0; i < 10; i++) begin
      do_reset();
      shr = vt[i].shr;
      fl  = vt[i].fl;
      ll  = vt[i].ll;
      go(vt[i].c);
      hraddr = vt[i].a;
      smp();
      chk("vec_slot", {45'd0, mem_req, mem_wr, mem_addr},
          {45'd0, vt[i].req, 1'b0,
           vt[i].req ? vt[i].a : 17'h0});
    end

    // video read, then underrun with late data discarded
    do_reset();
    shr = 1'b1;
    fl  = 1'b1;
    go(0); go(1); go(2);
    go(3);
    hraddr = 17'h00010;
    smp();
    chk("vid_req", {45'd0, mem_req, mem_wr, mem_addr},
        {45'd0, 1'b1, 1'b0, 17'h00010});
    go(4);
    rvalid = 1'b1;
    rdata  = 32'hA1B2C3D4;
    go(5);
    smp();
    chk("vid_vrm", {32'd0, vrm_32}, {32'd0, 32'hA1B2C3D4});
    chk("vid_no_underrun", {63'd0, underrun}, 64'd0);
    go(6); go(7); go(8);
    go(9);
    rvalid = 1'b1;
    rdata  = 32'hDEADBEEF;
    smp();
    chk("udr_vrm_hold", {32'd0, vrm_32}, {32'd0, 32'hA1B2C3D4});
    chk("udr_flag", {63'd0, underrun}, 64'd1);
    go(10);
    shr = 1'b0;
    smp();
    chk("late_discard", {32'd0, vrm_32}, {32'd0, 32'hA1B2C3D4});
    go(11);
    smp();
    chk("udr_sticky_fall", {63'd0, underrun}, 64'd1);
    go(12);
    shr = 1'b1;
    go(13);
    smp();
    chk("udr_clear_rise", {63'd0, underrun}, 64'd0);

    // CPU write in non-super mode
    do_reset();
    go(0);
    cpu_wr(17'h00100, 2'd2, 8'h5A);
    go(1);
    smp();
    chk("cpu_busy_set", {63'd0, cpu_busy}, 64'd1);
    go(2);
    go(3);
    smp();
    chk("cpu_write", wr_pack(),
        {7'd0, 1'b1, 1'b1, 17'h00100, 32'h5A5A5A5A, 4'b0100});
    go(4);
    smp();
    chk("cpu_no_early_ack", {62'd0, cpu_wr_ack, cpu_busy}, 64'd1);
    go(5);
    smp();
    chk("cpu_ack", {63'd0, cpu_wr_ack}, 64'd1);
    go(6);
    smp();
    chk("cpu_ack_done", {62'd0, cpu_wr_ack, cpu_busy}, 64'd0);

    // write starved by video for a whole line; busy ignores reqs
    do_reset();
    shr = 1'b1;
    fl  = 1'b1;
    go(0);
    cpu_wr(17'h1ABCD, 2'd1, 8'h3C);
    bad = 0;
    for (int c = 1; c < 723; c++) begin
      go(11'(c));
      if (c == 9) cpu_wr(17'h00001, 2'd3, 8'hEE);
      if ((c % 4) == 0) begin
        rvalid = 1'b1;
        rdata  = 32'(c);
      end
      smp();
      if (mem_req && mem_wr) bad++;
    end
    chk("starve_no_write", 64'(bad), 64'd0);
    chk("starve_busy", {63'd0, cpu_busy}, 64'd1);
    go(723);
    smp();
    chk("starve_write_723", wr_pack(),
        {7'd0, 1'b1, 1'b1, 17'h1ABCD, 32'h3C3C3C3C, 4'b0010});

    // reset during CPU_WAIT
    do_reset();
    go(0);
    cpu_wr(17'h0F0F0, 2'd3, 8'hC3);
    go(1); go(2);
    go(3);
    smp();
    chk("rst_write_issued", {62'd0, mem_req, mem_wr}, 64'd3);
    go(4);
    reset_n = 1'b0;
    smp();
    chk("rst_mid_outs", outs(), 64'd0);
    go(5);
    smp();
    chk("rst_mid_no_ack", {63'd0, cpu_wr_ack}, 64'd0);
    go(6);
    reset_n = 1'b1;
    smp();
    chk("rst_rel_busy", {62'd0, cpu_wr_ack, cpu_busy}, 64'd0);
    go(7);
    smp();
    chk("rst_write_dropped", {63'd0, mem_req}, 64'd0);

    // video priority, then abort on mode exit keeps the write
    do_reset();
    shr = 1'b1;
    fl  = 1'b1;
    go(0);
    cpu_wr(17'h00222, 2'd0, 8'h11);
    go(1); go(2);
    go(3);
    hraddr = 17'h00abc;
    smp();
    chk("prio_video", {45'd0, mem_req, mem_wr, mem_addr},
        {45'd0, 1'b1, 1'b0, 17'h00abc});
    go(4);
    shr = 1'b0;
    go(5);
    smp();
    chk("abort_state", {62'd0, cpu_busy, underrun}, 64'd2);
    go(6);
    go(7);
    smp();
    chk("abort_write", wr_pack(),
        {7'd0, 1'b1, 1'b1, 17'h00222, 32'h11111111, 4'b0001});
    go(8);
    go(9);
    smp();
    chk("abort_ack", {63'd0, cpu_wr_ack}, 64'd1);

    // randomized run against slot-level model
    do_reset();
    m_busy     = 1'b0;
    m_addr     = '0;
    m_lane     = '0;
    m_data     = '0;
    m_vrm      = '0;
    m_under    = 1'b0;
    m_shr_prev = 1'b0;
    slot       = 0;
    vid_lat    = 0;
    vid_data   = '0;
    held       = '0;
    for (int n = 0; n < 4 * 728; n++) begin
      int c;
      int ph;
      int nslot;
      logic        e_req;
      logic        e_wr;
      logic [16:0] e_addr;
      logic [31:0] e_wdata;
      logic [3:0]  e_mask;
      logic        e_ack;
      logic        vid;
      c  = n % 728;
      ph = c % 4;
      go(11'(c));
      if (c == 2) begin
        shr = ($urandom % 4) != 0;
        fl  = ($urandom % 2) != 0;
        ll  = ($urandom % 3) == 0;
      end
      hraddr = 17'($urandom);
      if (($urandom % 6) == 0)
        cpu_wr(17'($urandom), 2'($urandom), 8'($urandom));
      if (slot == 1) begin
        if (ph == 0 && vid_lat == 1) begin
          rvalid = 1'b1;
          rdata  = vid_data;
        end else if (ph == 1 && vid_lat == 2) begin
          rvalid = 1'b1;
          rdata  = $urandom;
        end
      end else begin
        rvalid = 1'($urandom);
        rdata  = $urandom;
      end
      e_req   = 1'b0;
      e_wr    = 1'b0;
      e_addr  = '0;
      e_wdata = '0;
      e_mask  = '0;
      e_ack   = 1'b0;
      nslot   = 0;
      if (ph == 3) begin
        vid = shr && ((fl && c < 720) || (c == 723 && ll));
        if (vid) begin
          e_req  = 1'b1;
          e_addr = hraddr;
          nslot  = 1;
        end else if (m_busy) begin
          e_req   = 1'b1;
          e_wr    = 1'b1;
          e_addr  = m_addr;
          e_wdata = {4{m_data}};
          e_mask  = 4'b0001 << m_lane;
          nslot   = 2;
        end
      end
      if (ph == 1 && slot == 2) e_ack = 1'b1;
      smp();
      chk("rand_outs", outs(),
          {6'd0, e_req, e_wr, e_addr, e_wdata, e_mask,
           e_ack, m_busy, m_under});
      chk("rand_vrm", {32'd0, vrm_32}, {32'd0, m_vrm});
      if (shr && !m_shr_prev) m_under = 1'b0;
      else if (slot == 1 && ph == 0 && vid_lat != 1)
        m_under = 1'b1;
      if (slot == 1 && ph == 0 && vid_lat == 1)
        m_vrm = vid_data;
      if (wr_req && !m_busy) begin
        m_busy = 1'b1;
        m_addr = c_addr;
        m_lane = c_lane;
        m_data = c_data;
      end else if (e_ack) begin
        m_busy = 1'b0;
      end
      if (ph == 1) slot = 0;
      if (ph == 3) begin
        slot     = nslot;
        vid_lat  = int'($urandom % 3);
        vid_data = $urandom;
      end
      m_shr_prev = shr;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
